// File: rtl/mux_seq_n_to_one_if.sv
// Bus bundle for mux_seq_n_to_one: the input channels, the request controls and the
// registered output beat together with its valid/ready handshake.
interface mux_seq_n_to_one_if #(
    parameter int WIDTH = 16,
    parameter int N     = 6,
    parameter int SELW  = 3
);
    logic [N*WIDTH-1:0] entradas;
    logic [SELW-1:0]    op;
    logic               modo;
    logic               carrega;
    logic               inicio;
    logic               pronto;
    logic [WIDTH-1:0]   saida;
    logic [SELW-1:0]    canal;
    logic               valido;
    logic               fim;
    logic               erro;
    logic [1:0]         estado;

    // Handshake: a beat (saida, canal, fim) moves on a rising edge where valido && pronto;
    // while valido && !pronto the beat holds stable, and valido never drops without a transfer.
    modport master (
        output entradas, op, modo, carrega, inicio, pronto,
        input  saida, canal, valido, fim, erro, estado
    );

    modport slave (
        input  entradas, op, modo, carrega, inicio, pronto,
        output saida, canal, valido, fim, erro, estado
    );
endinterface

// File: rtl/mux_seq_n_to_one.sv
// Registered N-to-1 channel selector with a direct (op-addressed) mode and an automatic
// scan mode that walks all N channels, one beat per accepted transfer.
module mux_seq_n_to_one #(
    parameter int WIDTH = 16,
    parameter int N     = 6,
    parameter int SELW  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    mux_seq_n_to_one_if.slave     bus
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] DIRETO = 2'd1;
    localparam logic [1:0] VARRE  = 2'd2;

    localparam int              NUM_SEL    = 2 ** SELW;
    localparam logic [SELW:0]   NUM_CANAIS = (SELW + 1)'(N);
    localparam logic [SELW-1:0] ULTIMO     = SELW'(N - 1);

    logic [1:0]       estado;
    logic [WIDTH-1:0] saida;
    logic [SELW-1:0]  canal;
    logic             valido;
    logic             fim;
    logic             erro;

    // Padded to the full select range so any op value indexes a defined (zero) entry.
    logic [WIDTH-1:0] canais [NUM_SEL];

    for (genvar k = 0; k < NUM_SEL; k++) begin : g_canais
        if (k < N) begin : g_real
            assign canais[k] = bus.entradas[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign canais[k] = '0;
        end
    end

    logic            transfere;
    logic            op_valido;
    logic [SELW-1:0] canal_prox;

    assign transfere  = valido && bus.pronto;
    assign op_valido  = ({1'b0, bus.op} < NUM_CANAIS);
    assign canal_prox = canal + SELW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            saida  <= '0;
            canal  <= '0;
            valido <= 1'b0;
            fim    <= 1'b0;
            erro   <= 1'b0;
        end else begin
            erro <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (bus.modo && bus.inicio) begin
                        saida  <= canais[0];
                        canal  <= '0;
                        valido <= 1'b1;
                        fim    <= (ULTIMO == '0);
                        estado <= VARRE;
                    end else if (!bus.modo && bus.carrega) begin
                        if (op_valido) begin
                            saida  <= canais[bus.op];
                            canal  <= bus.op;
                            valido <= 1'b1;
                            estado <= DIRETO;
                        end else begin
                            saida <= '0;
                            erro  <= 1'b1;
                        end
                    end
                end

                DIRETO: begin
                    // Requests arriving in the transfer cycle are dropped: a new
                    // direct beat can only be accepted from OCIOSO.
                    if (transfere) begin
                        valido <= 1'b0;
                        estado <= OCIOSO;
                    end
                end

                VARRE: begin
                    if (transfere) begin
                        if (canal == ULTIMO) begin
                            valido <= 1'b0;
                            fim    <= 1'b0;
                            estado <= OCIOSO;
                        end else begin
                            canal <= canal_prox;
                            saida <= canais[canal_prox];
                            fim   <= (canal_prox == ULTIMO);
                        end
                    end
                end

                default: begin
                    valido <= 1'b0;
                    fim    <= 1'b0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.saida  = saida;
    assign bus.canal  = canal;
    assign bus.valido = valido;
    assign bus.fim    = fim;
    assign bus.erro   = erro;
    assign bus.estado = estado;

endmodule

// File: tb/tb_mux_seq_n_to_one.sv
// Directed bench for mux_seq_n_to_one: expected beats are queued when a request is
// issued and popped by a monitor whenever the DUT hands a beat over.
module tb_mux_seq_n_to_one;
    localparam int WIDTH = 16;
    localparam int N     = 6;
    localparam int SELW  = 3;
    localparam int W     = WIDTH + SELW + 1;

    localparam logic [1:0] S_OCIOSO = 2'd0;
    localparam logic [1:0] S_DIRETO = 2'd1;
    localparam logic [1:0] S_VARRE  = 2'd2;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mux_seq_n_to_one_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

    mux_seq_n_to_one #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0]     exp_q [$];
    logic [WIDTH-1:0] chan [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input logic [WIDTH-1:0] c0, c1, c2, c3, c4, c5);
        chan[0] = c0; chan[1] = c1; chan[2] = c2;
        chan[3] = c3; chan[4] = c4; chan[5] = c5;
        for (int k = 0; k < N; k++) bus.entradas[k*WIDTH +: WIDTH] = chan[k];
    endtask

    task automatic push_scan();
        for (int k = 0; k < N; k++) exp_q.push_back({(k == N-1), SELW'(k), chan[k]});
    endtask

    // Scoreboard: every accepted beat must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset && bus.valido && bus.pronto) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL beat_unexpected observed=%0h expected=none",
                           {bus.fim, bus.canal, bus.saida});
                end
            end else begin
                check("beat", 32'({bus.fim, bus.canal, bus.saida}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.entradas = '0;
        bus.op       = '0;
        bus.modo     = 1'b0;
        bus.carrega  = 1'b0;
        bus.inicio   = 1'b0;
        bus.pronto   = 1'b0;
        step();
        step();
        check("rst_valido", 32'(bus.valido), 32'(0));
        check("rst_saida",  32'(bus.saida),  32'(0));
        check("rst_canal",  32'(bus.canal),  32'(0));
        check("rst_fim",    32'(bus.fim),    32'(0));
        check("rst_erro",   32'(bus.erro),   32'(0));
        check("rst_estado", 32'(bus.estado), 32'(S_OCIOSO));
        reset = 1'b0;

        // Direct sweep
        set_ch(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
        bus.pronto = 1'b1;
        bus.modo   = 1'b0;
        for (int op = 0; op < N; op++) begin
            bus.op      = SELW'(op);
            bus.carrega = 1'b1;
            exp_q.push_back({1'b0, SELW'(op), WIDTH'(op + 1)});
            step();
            bus.carrega = 1'b0;
            check("dir_valido", 32'(bus.valido), 32'(1));
            check("dir_saida",  32'(bus.saida),  32'(op + 1));
            check("dir_canal",  32'(bus.canal),  32'(op));
            check("dir_estado", 32'(bus.estado), 32'(S_DIRETO));
            check("dir_erro",   32'(bus.erro),   32'(0));
            step();
            check("dir_valido_low", 32'(bus.valido), 32'(0));
            check("dir_estado_ret", 32'(bus.estado), 32'(S_OCIOSO));
        end

        // Out of range
        for (int op = N; op < 2**SELW; op++) begin
            bus.op      = SELW'(op);
            bus.carrega = 1'b1;
            step();
            bus.carrega = 1'b0;
            check("oor_erro",   32'(bus.erro),   32'(1));
            check("oor_valido", 32'(bus.valido), 32'(0));
            check("oor_saida",  32'(bus.saida),  32'(0));
            check("oor_estado", 32'(bus.estado), 32'(S_OCIOSO));
            step();
            check("oor_erro_pulse", 32'(bus.erro), 32'(0));
        end

        // Full scan at one beat per cycle
        set_ch(16'd10, 16'd20, 16'd30, 16'd4, 16'd5, 16'd6);
        bus.modo   = 1'b1;
        bus.inicio = 1'b1;
        push_scan();
        step();
        bus.inicio = 1'b0;
        check("scan_first_saida", 32'(bus.saida), 32'(10));
        for (int k = 0; k < N; k++) begin
            check("scan_canal", 32'(bus.canal),  32'(k));
            check("scan_fim",   32'(bus.fim),    32'(k == N-1));
            check("scan_valido", 32'(bus.valido), 32'(1));
            step();
        end
        check("scan_drained", 32'(exp_q.size()), 32'(0));
        check("scan_end_valido", 32'(bus.valido), 32'(0));
        check("scan_end_estado", 32'(bus.estado), 32'(S_OCIOSO));

        // Back-pressure while canal=2
        bus.inicio = 1'b1;
        push_scan();
        step();
        bus.inicio = 1'b0;
        step();
        step();
        check("bp_canal", 32'(bus.canal), 32'(2));
        bus.pronto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_saida",  32'(bus.saida),  32'(30));
            check("bp_hold_canal",  32'(bus.canal),  32'(2));
            check("bp_hold_valido", 32'(bus.valido), 32'(1));
        end
        bus.pronto = 1'b1;
        step();
        check("bp_resume_saida", 32'(bus.saida), 32'(4));
        check("bp_resume_canal", 32'(bus.canal), 32'(3));
        repeat (3) step();
        check("bp_drained", 32'(exp_q.size()), 32'(0));
        check("bp_end_valido", 32'(bus.valido), 32'(0));

        // inicio beats carrega; carrega and modo=0 are ignored mid-scan
        bus.inicio  = 1'b1;
        bus.carrega = 1'b1;
        bus.op      = 3'd3;
        push_scan();
        step();
        bus.inicio = 1'b0;
        check("pri_estado", 32'(bus.estado), 32'(S_VARRE));
        check("pri_saida",  32'(bus.saida),  32'(10));
        bus.op   = 3'd1;
        bus.modo = 1'b0;
        repeat (3) step();
        check("pri_mid_estado", 32'(bus.estado), 32'(S_VARRE));
        check("pri_mid_canal",  32'(bus.canal),  32'(3));
        repeat (3) step();
        bus.carrega = 1'b0;
        check("pri_drained", 32'(exp_q.size()), 32'(0));
        check("pri_end_estado", 32'(bus.estado), 32'(S_OCIOSO));
        step();
        check("pri_idle_valido", 32'(bus.valido), 32'(0));

        // Reset mid-scan at canal=3
        bus.modo   = 1'b1;
        bus.inicio = 1'b1;
        push_scan();
        step();
        bus.inicio = 1'b0;
        repeat (3) step();
        check("rms_canal", 32'(bus.canal), 32'(3));
        bus.pronto = 1'b0;
        reset      = 1'b1;
        exp_q.delete();
        step();
        check("rms_valido", 32'(bus.valido), 32'(0));
        check("rms_saida",  32'(bus.saida),  32'(0));
        check("rms_canal0", 32'(bus.canal),  32'(0));
        check("rms_fim",    32'(bus.fim),    32'(0));
        check("rms_estado", 32'(bus.estado), 32'(S_OCIOSO));
        reset      = 1'b0;
        bus.pronto = 1'b1;
        bus.inicio = 1'b1;
        push_scan();
        step();
        bus.inicio = 1'b0;
        check("rms_restart_saida", 32'(bus.saida), 32'(10));
        check("rms_restart_canal", 32'(bus.canal), 32'(0));
        repeat (N) step();
        check("rms_drained", 32'(exp_q.size()), 32'(0));
        check("rms_end_valido", 32'(bus.valido), 32'(0));

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_seq_n_to_one.md
Name: mux_seq_n_to_one

Overview:
Parametrised, registered N-to-1 selector for the multiplier datapath; successor to the fixed 6-input combinational selector.
- Direct mode: returns the operand chosen by `op` one cycle after a load request.
- Scan mode: steps automatically through all N channels, presenting one per beat.
- Output uses a valid/ready handshake, so downstream accumulate/shift stages can back-pressure it.

Parameters:
WIDTH, 16, data width of each input channel and of saida
N, 6, number of input channels (2..2**SELW)
SELW, 3, width of op and canal

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
entradas  input  N*WIDTH  flattened channels; channel k = entradas[k*WIDTH +: WIDTH]
op  input  SELW  channel select, direct mode
modo  input  1  0 = direct, 1 = scan; sampled only in OCIOSO
carrega  input  1  direct-mode capture request
inicio  input  1  scan-mode start pulse
pronto  input  1  downstream ready
saida  output  WIDTH  registered selected data
canal  output  SELW  index of channel currently on saida
valido  output  1  saida/canal valid
fim  output  1  high with the last beat of a scan
erro  output  1  one-cycle flag: direct request with op >= N

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state = OCIOSO.
  - saida = 0, canal = 0, valido = 0, fim = 0, erro = 0.
  - Reset mid-scan or mid-handshake aborts immediately; no beat is delivered afterwards.
- Handshake:
  - A beat transfers on a clock edge with valido && pronto.
  - While valido && !pronto, saida, canal and fim hold stable and all new requests are ignored.
- States: OCIOSO, DIRETO, VARRE.
- OCIOSO, modo=0, carrega=1:
  - If op < N: next edge loads saida = channel[op], canal = op, valido = 1 (latency 1 cycle); go to DIRETO.
  - If op >= N: saida = 0, valido stays 0, erro = 1 for exactly one cycle; remain OCIOSO.
- DIRETO:
  - On transfer, valido = 0 and return to OCIOSO.
  - A carrega in the transfer cycle is ignored; back-to-back direct beats therefore take 2 cycles each.
- OCIOSO, modo=1, inicio=1:
  - Next edge: saida = channel[0], canal = 0, valido = 1; go to VARRE.
  - inicio takes priority over carrega when both are asserted.
- VARRE:
  - On each transfer with canal < N-1: canal increments, saida = channel[canal+1], valido stays 1.
  - This gives a throughput of 1 beat/cycle while pronto=1.
  - fim = 1 while canal == N-1 and valido = 1.
  - On transfer of the last beat: valido = 0, fim = 0, return to OCIOSO.
- Ignored while not in OCIOSO: inicio, carrega and modo changes.
- Sampling rule: saida captures entradas at load/advance time; later input changes do not affect a held beat.
- Arithmetic: canal never wraps; the increment is bounded at N-1. No arithmetic on data, pure selection.
- N=2**SELW: no op value is out of range, so erro is never asserted.

Test Plan:
- Direct sweep:
  - Stimulus: channels 1,2,3,4,5,6; pronto=1; carrega with op=0..5 in turn.
  - Required: saida = op+1 one cycle after each request; valido high one cycle; canal = op.
- Out of range:
  - Stimulus: op=6 and op=7 with carrega.
  - Required: erro pulses one cycle each; valido stays 0; saida = 0; state stays OCIOSO.
- Full scan:
  - Stimulus: channels 10,20,30,4,5,6; modo=1; inicio; pronto=1.
  - Required: saida = 10,20,30,4,5,6 on 6 consecutive cycles; canal 0..5; fim only with 6.
- Back-pressure:
  - Stimulus: scan as above with pronto=0 for 3 cycles while canal=2.
  - Required: saida = 30 and canal = 2 held stable; sequence resumes with 4 when pronto=1.
- Priority/ignore:
  - Stimulus: inicio and carrega together in OCIOSO; then carrega (and separately modo=0) asserted during VARRE.
  - Required: scan runs; mid-scan carrega and modo changes have no effect.
- Reset mid-scan:
  - Stimulus: reset asserted while canal=3.
  - Required: next edge gives valido = 0, saida = 0, canal = 0, fim = 0; a new inicio restarts from channel 0.
